// File: rtl/light_phase_timer.sv
// Phase countdown for a traffic-light sequencer: times RED/GREEN/YELLOW, strobes step,
// shortens GREEN on pedestrian request and latches a sticky fault on illegal sequencing.
module light_phase_timer #(
  parameter int unsigned RED_TICKS    = 5,
  parameter int unsigned GREEN_TICKS  = 4,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned PED_TICKS    = 2,
  parameter int unsigned WAIT_MAX     = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       light,
  input  logic             hold,
  input  logic             ped_req,
  output logic             step,
  output logic [CNT_W-1:0] remaining,
  output logic             ped_ack,
  output logic             fault
);

  localparam logic [2:0] LightRed    = 3'b100;
  localparam logic [2:0] LightGreen  = 3'b010;
  localparam logic [2:0] LightYellow = 3'b001;

  localparam logic [CNT_W-1:0] RedDur    = CNT_W'(RED_TICKS);
  localparam logic [CNT_W-1:0] GreenDur  = CNT_W'(GREEN_TICKS);
  localparam logic [CNT_W-1:0] YellowDur = CNT_W'(YELLOW_TICKS);
  localparam logic [CNT_W-1:0] PedDur    = CNT_W'(PED_TICKS);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  localparam int unsigned WaitW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {StIdle, StRun, StWaitChg, StFault} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               step_q, step_d;
  logic               ped_ack_q, ped_ack_d;
  logic               fault_q, fault_d;
  logic               ped_pend_q, ped_pend_d;
  logic [2:0]         prev_light_q, prev_light_d;
  logic [WaitW-1:0]   wait_q, wait_d;

  function automatic logic is_legal(input logic [2:0] l);
    return (l == LightRed) || (l == LightGreen) || (l == LightYellow);
  endfunction

  function automatic logic [CNT_W-1:0] dur(input logic [2:0] l);
    logic [CNT_W-1:0] d;
    case (l)
      LightRed:    d = RedDur;
      LightGreen:  d = GreenDur;
      LightYellow: d = YellowDur;
      default:     d = '0;
    endcase
    return d;
  endfunction

  logic pend_eff;
  logic ack;
  logic go_fault;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    step_d       = 1'b0;
    fault_d      = fault_q;
    prev_light_d = prev_light_q;
    wait_d       = wait_q;
    ack          = 1'b0;
    go_fault     = 1'b0;
    // A request arriving this cycle already counts towards shortening GREEN.
    pend_eff     = ped_pend_q | ped_req;

    unique case (state_q)
      StIdle: begin
        if (is_legal(light)) begin
          remaining_d  = dur(light);
          prev_light_d = light;
          state_d      = StRun;
          ack          = (light == LightRed) && ped_pend_q;
        end else begin
          go_fault = 1'b1;
        end
      end
      StRun: begin
        if (light != prev_light_q) begin
          go_fault = 1'b1;
        end else if (!hold) begin
          if (remaining_q <= CntOne) begin
            step_d      = 1'b1;
            remaining_d = '0;
            wait_d      = '0;
            state_d     = StWaitChg;
          end else if ((light == LightGreen) && pend_eff && (remaining_q > PedDur)) begin
            remaining_d = PedDur;
          end else begin
            remaining_d = remaining_q - CntOne;
          end
        end
      end
      StWaitChg: begin
        if (light == prev_light_q) begin
          if ((32'(wait_q) + 32'd1) >= WAIT_MAX) begin
            go_fault = 1'b1;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end else if (is_legal(light)) begin
          remaining_d  = dur(light);
          prev_light_d = light;
          state_d      = StRun;
          ack          = (light == LightRed) && ped_pend_q;
        end else begin
          go_fault = 1'b1;
        end
      end
      StFault: begin
        go_fault = 1'b1;
      end
    endcase

    if (go_fault) begin
      state_d     = StFault;
      fault_d     = 1'b1;
      remaining_d = '0;
      step_d      = 1'b0;
      ack         = 1'b0;
    end

    ped_ack_d  = ack;
    // Set wins over the clear on acknowledge.
    ped_pend_d = (ped_pend_q & ~ack) | ped_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      step_q       <= 1'b0;
      ped_ack_q    <= 1'b0;
      fault_q      <= 1'b0;
      ped_pend_q   <= 1'b0;
      prev_light_q <= 3'b000;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      step_q       <= step_d;
      ped_ack_q    <= ped_ack_d;
      fault_q      <= fault_d;
      ped_pend_q   <= ped_pend_d;
      prev_light_q <= prev_light_d;
      wait_q       <= wait_d;
    end
  end

  assign step      = step_q;
  assign remaining = remaining_q;
  assign ped_ack   = ped_ack_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_light_phase_timer.sv
// Randomized bench for light_phase_timer: a phase-level reference model predicts every
// registered output each cycle while a sequencer model answers step with a new light code.
module tb_light_phase_timer;

  localparam int unsigned RED_TICKS    = 5;
  localparam int unsigned GREEN_TICKS  = 4;
  localparam int unsigned YELLOW_TICKS = 2;
  localparam int unsigned PED_TICKS    = 2;
  localparam int unsigned WAIT_MAX     = 4;
  localparam int unsigned CNT_W        = 8;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;

  logic             clk;
  logic             rst_n;
  logic [2:0]       light;
  logic             hold;
  logic             ped_req;
  logic             step;
  logic [CNT_W-1:0] remaining;
  logic             ped_ack;
  logic             fault;

  int n_vec;
  int n_err;

  light_phase_timer #(
    .RED_TICKS   (RED_TICKS),
    .GREEN_TICKS (GREEN_TICKS),
    .YELLOW_TICKS(YELLOW_TICKS),
    .PED_TICKS   (PED_TICKS),
    .WAIT_MAX    (WAIT_MAX),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .light    (light),
    .hold     (hold),
    .ped_req  (ped_req),
    .step     (step),
    .remaining(remaining),
    .ped_ack  (ped_ack),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase bookkeeping in plain integers.
  bit         m_fault, m_started, m_counting, m_pend, m_step, m_ack;
  int         m_left, m_waited;
  logic [2:0] m_phase;

  function automatic int phase_len(input logic [2:0] l);
    if (l == RED)    return RED_TICKS;
    if (l == GREEN)  return GREEN_TICKS;
    if (l == YELLOW) return YELLOW_TICKS;
    return -1;
  endfunction

  function automatic logic [2:0] next_light(input logic [2:0] l);
    if (l == RED)   return GREEN;
    if (l == GREEN) return YELLOW;
    return RED;
  endfunction

  task automatic model_reset();
    m_fault = 0; m_started = 0; m_counting = 0; m_pend = 0; m_step = 0; m_ack = 0;
    m_left = 0; m_waited = 0; m_phase = 3'b000;
  endtask

  task automatic enter_phase(input logic [2:0] l);
    m_left     = phase_len(l);
    m_phase    = l;
    m_counting = 1;
    if (l == RED && m_pend) m_ack = 1;
  endtask

  task automatic model_clock(input logic [2:0] l, input bit h, input bit p);
    bit want_short;
    m_step = 0;
    m_ack  = 0;
    want_short = m_pend || p;
    if (m_fault) begin
      // sticky
    end else if (!m_started) begin
      m_started = 1;
      if (phase_len(l) > 0) enter_phase(l);
      else m_fault = 1;
    end else if (m_counting) begin
      if (l != m_phase) m_fault = 1;
      else if (!h) begin
        if (m_left == 1) begin
          m_step = 1; m_left = 0; m_counting = 0; m_waited = 0;
        end else if (l == GREEN && want_short && m_left > PED_TICKS) begin
          m_left = PED_TICKS;
        end else begin
          m_left = m_left - 1;
        end
      end
    end else begin
      if (l == m_phase) begin
        m_waited++;
        if (m_waited >= WAIT_MAX) m_fault = 1;
      end else if (phase_len(l) > 0) enter_phase(l);
      else m_fault = 1;
    end
    if (m_fault) begin
      m_left = 0; m_step = 0; m_ack = 0;
    end
    if (m_ack) m_pend = 0;
    if (p) m_pend = 1;
  endtask

  // One clock with given inputs; entered and left at a falling edge.
  task automatic cycle(input logic [2:0] l, input bit h, input bit p);
    light = l; hold = h; ped_req = p;
    @(posedge clk);
    model_clock(l, h, p);
    #1;
    check_eq("step", 32'(step), 32'(m_step));
    check_eq("remaining", 32'(remaining), 32'(m_left));
    check_eq("ped_ack", 32'(ped_ack), 32'(m_ack));
    check_eq("fault", 32'(fault), 32'(m_fault));
    @(negedge clk);
  endtask

  // Sequencer model: after a step, presents the next code (or a bad one) after a delay.
  logic [2:0] cur_light;
  bit         chg_pend;
  int         chg_dly;

  task automatic run_seq(input int n, input int hold_pct, input int ped_pct,
                         input int max_delay, input bit bad_code);
    for (int i = 0; i < n; i++) begin
      if (chg_pend) begin
        if (chg_dly == 0) begin
          cur_light = bad_code ? 3'b110 : next_light(cur_light);
          chg_pend  = 0;
        end else begin
          chg_dly--;
        end
      end
      cycle(cur_light, $urandom_range(99) < hold_pct, $urandom_range(99) < ped_pct);
      if (step === 1'b1) begin
        chg_pend = 1;
        chg_dly  = $urandom_range(max_delay);
      end
    end
  endtask

  // Asserts reset away from any rising edge and checks the outputs clear at once.
  task automatic apply_reset(input logic [2:0] l);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_step", 32'(step), 32'd0);
    check_eq("rst_remaining", 32'(remaining), 32'd0);
    check_eq("rst_ped_ack", 32'(ped_ack), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    model_reset();
    chg_pend  = 0;
    chg_dly   = 0;
    cur_light = l;
    light     = l;
    hold      = 1'b0;
    ped_req   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; light = RED; hold = 1'b0; ped_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean cycle through all phases, then random hold and pedestrian traffic.
    apply_reset(RED);
    run_seq(30, 0, 0, 0, 0);
    run_seq(400, 20, 10, 2, 0);

    // Sequencer never answers the step: wait counter must expire into fault.
    apply_reset(RED);
    run_seq(20, 0, 0, 1000, 0);

    // Illegal code at reset release.
    apply_reset(3'b011);
    run_seq(4, 0, 0, 0, 0);

    // Illegal code presented while waiting for the change.
    apply_reset(RED);
    run_seq(12, 0, 0, 1, 1);

    // Unexpected light change mid-phase.
    apply_reset(RED);
    run_seq(3, 0, 0, 0, 0);
    cur_light = GREEN;
    run_seq(3, 0, 0, 0, 0);

    // Reset in RUN at remaining 3, then reload from the current light.
    apply_reset(RED);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (m_counting && m_left == 3 && !m_fault) found = 1;
      else run_seq(1, 0, 20, 1, 0);
    end
    check_eq("find_rem3", 32'(found), 32'd1);
    apply_reset(cur_light);
    run_seq(40, 10, 10, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/light_phase_timer.md
LIGHT_PHASE_TIMER -- requirements
Module: light_phase_timer

Interface
REQ-001 Parameter RED_TICKS, default 5, RED phase length in clk cycles (>=2).
REQ-002 Parameter GREEN_TICKS, default 4, GREEN phase length in clk cycles (>=2).
REQ-003 Parameter YELLOW_TICKS, default 2, YELLOW phase length in clk cycles (>=2).
REQ-004 Parameter PED_TICKS, default 2, shortened GREEN remainder on pedestrian request (1..GREEN_TICKS-1).
REQ-005 Parameter WAIT_MAX, default 4, maximum cycles allowed for the light code to change after a step.
REQ-006 Parameter CNT_W, default 8, counter width; every *_TICKS SHALL be < 2^CNT_W.
REQ-007 clk  input  1  single clock, all state SHALL update on the rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 light  input  3  current lamp code from the phase sequencer: RED=100, GREEN=010, YELLOW=001; any other value is illegal.
REQ-010 hold  input  1  freezes countdown while high.
REQ-011 ped_req  input  1  pedestrian request, level or pulse, sampled every cycle.
REQ-012 step  output  1  registered one-cycle strobe instructing the sequencer to advance phase.
REQ-013 remaining  output  CNT_W  registered cycles left in the current phase.
REQ-014 ped_ack  output  1  registered one-cycle strobe when a pending request is served.
REQ-015 fault  output  1  registered sticky error flag.

Function
REQ-016 FSM states SHALL be IDLE, RUN, WAIT_CHG, FAULT.
REQ-017 dur(light) SHALL be RED_TICKS, GREEN_TICKS or YELLOW_TICKS for RED, GREEN or YELLOW respectively.
REQ-018 IDLE: on the first clock edge after reset release, legal light -> remaining=dur(light), prev_light=light, go RUN; illegal -> FAULT.
REQ-019 RUN, hold=1: remaining, state and step SHALL remain unchanged (step=0).
REQ-020 RUN, hold=0, remaining>1: remaining decrements by 1.
REQ-021 RUN, hold=0, remaining==1: step=1 on the next cycle only, remaining=0, wait counter cleared, go WAIT_CHG.
REQ-022 step SHALL never be high for two consecutive cycles and SHALL only rise on the RUN->WAIT_CHG transition.
REQ-023 ped_req=1 in any cycle SHALL set a sticky ped_pend bit, including during hold, WAIT_CHG and IDLE.
REQ-024 RUN, light==GREEN, ped_pend=1, hold=0, remaining>PED_TICKS: remaining SHALL load PED_TICKS instead of decrementing (one shortening per GREEN phase).
REQ-025 WAIT_CHG: light==prev_light -> wait counter increments; reaching WAIT_MAX -> FAULT.
REQ-026 WAIT_CHG: legal light!=prev_light -> remaining=dur(light), prev_light=light, go RUN; hold has no effect on this load.
REQ-027 WAIT_CHG: illegal new light code -> FAULT.
REQ-028 Entering RUN with light==RED and ped_pend=1 SHALL pulse ped_ack for one cycle and clear ped_pend; ped_req in that same cycle re-sets ped_pend (set wins).
REQ-029 Light code change while in RUN (unexpected, not following a step) SHALL go FAULT.
REQ-030 FAULT: fault=1, step=0, remaining=0, ped_ack=0; exits only through reset.
REQ-031 remaining SHALL never underflow or wrap; minimum value 0.

Reset
REQ-032 rst_n low SHALL immediately force state=IDLE, step=0, remaining=0, ped_ack=0, fault=0, ped_pend=0, prev_light=000, wait counter=0.
REQ-033 Reset asserted mid-phase or in FAULT SHALL discard all progress; timing restarts via IDLE after release.

Verification
REQ-034 Reset release, light=100, hold=0, sequencer model advancing on step -> remaining 5,4,3,2,1,0; step high exactly 5 cycles after the IDLE load; GREEN then runs 4 cycles and YELLOW 2.
REQ-035 GREEN with remaining=4, ped_req one-cycle pulse -> remaining=2 next cycle, step 2 cycles later; ped_ack pulses once on entering RED.
REQ-036 hold=1 for 3 cycles at remaining=1 -> step delayed by exactly 3 cycles; remaining stays 1 throughout.
REQ-037 Step issued, light held constant -> fault=1 after 4 WAIT_CHG cycles; step stays 0; fault persists until rst_n low.
REQ-038 light=011 at reset release -> fault=1 on the first edge; light=110 in WAIT_CHG -> fault=1.
REQ-039 rst_n pulsed low in RUN with remaining=3 -> all outputs 0 asynchronously; after release the counter reloads dur(light).
